life_grid_engine: RTL

- Game of Life generation engine on a toroidal ROWS x COLS cell grid, held in registers.
- Sits directly upstream of the VGA renderer/sync stage. The renderer reads the current generation through a random-access read port and pulses step once per frame (e.g. on vsync).
- Computes the next generation one row per cycle into a shadow bank, then commits it atomically, so the displayed frame never tears.

---
 rtl/life_pkg.sv | 30 +++
 rtl/life_grid_engine_if.sv | 33 +++
 rtl/life_cell_rule.sv | 16 +
 rtl/life_grid_engine.sv | 121 ++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types and helpers for the Game of Life grid engine.
package life_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  localparam int GLIDER_N = 5;
  localparam int GLIDER_R [GLIDER_N] = '{0, 1, 2, 2, 2};
  localparam int GLIDER_C [GLIDER_N] = '{1, 2, 0, 1, 2};

  function automatic int wrap_inc(int i, int size);
    return (i + 1) % size;
  endfunction

  function automatic int wrap_dec(int i, int size);
    return (i + size - 1) % size;
  endfunction

  function automatic logic glider_at(int r, int c);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < GLIDER_N; i++)
      hit = hit | ((GLIDER_R[i] == r) && (GLIDER_C[i] == c));
    return hit;
  endfunction

endpackage

// File: rtl/life_grid_engine_if.sv
// Renderer-facing port bundle: step/busy/done, cell read port, seed write port.
interface life_grid_engine_if #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int GEN_W = 16
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic             step;
  logic             busy;
  logic             done;
  logic [RW-1:0]    rd_row;
  logic [CW-1:0]    rd_col;
  logic             rd_cell;
  logic             wr_en;
  logic [RW-1:0]    wr_row;
  logic [CW-1:0]    wr_col;
  logic             wr_val;
  logic [GEN_W-1:0] gen_count;

  modport master (
    output step, rd_row, rd_col,
    output wr_en, wr_row, wr_col, wr_val,
    input  busy, done, rd_cell, gen_count
  );

  modport slave (
    input  step, rd_row, rd_col,
    input  wr_en, wr_row, wr_col, wr_val,
    output busy, done, rd_cell, gen_count
  );
endinterface

// File: rtl/life_cell_rule.sv
// Conway rule for one cell: birth on 3, survival on 2 or 3.
module life_cell_rule (
  input  logic       self,
  input  logic [7:0] nb,
  output logic       nxt
);
  logic [3:0] n;

  always_comb begin
    n = '0;
    for (int i = 0; i < 8; i++)
      n = n + {3'b000, nb[i]};
  end

  assign nxt = (n == 4'd3) | (self & (n == 4'd2));
endmodule

// File: rtl/life_grid_engine.sv
// Toroidal Life engine: one row per cycle into a shadow bank,
// then an atomic commit so the displayed generation never tears.
module life_grid_engine
  import life_pkg::*;
#(
  parameter int ROWS        = 16,
  parameter int COLS        = 16,
  parameter int SEED_GLIDER = 1,
  parameter int GEN_W       = 16
) (
  input logic dclk,
  input logic clr,
  life_grid_engine_if.slave bus
);
  localparam int RW = $clog2(ROWS);

  typedef logic [ROWS-1:0][COLS-1:0] grid_t;

  function automatic grid_t seed_grid();
    grid_t g;
    g = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        g[r][c] = (SEED_GLIDER != 0) && glider_at(r, c);
    return g;
  endfunction

  localparam grid_t SEED = seed_grid();

  state_t           state;
  state_t           state_nx;
  logic             busy;
  logic             done_q;
  logic [RW-1:0]    row_idx;
  logic [RW-1:0]    row_up;
  logic [RW-1:0]    row_dn;
  logic             last_row;
  logic [GEN_W-1:0] gen;
  grid_t            cur;
  grid_t            nxt;
  logic [COLS-1:0]  up;
  logic [COLS-1:0]  mid;
  logic [COLS-1:0]  dn;
  logic [COLS-1:0]  nrow;

  assign row_up   = RW'(wrap_dec(int'(row_idx), ROWS));
  assign row_dn   = RW'(wrap_inc(int'(row_idx), ROWS));
  assign last_row = (row_idx == RW'(ROWS - 1));
  assign up       = cur[row_up];
  assign mid      = cur[row_idx];
  assign dn       = cur[row_dn];

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int CL = wrap_dec(c, COLS);
    localparam int CR = wrap_inc(c, COLS);
    life_cell_rule u_rule (
      .self (mid[c]),
      .nb   ({up[CL], up[c], up[CR],
              mid[CL], mid[CR],
              dn[CL], dn[c], dn[CR]}),
      .nxt  (nrow[c])
    );
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.step) state_nx = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        busy = 1'b1;
        if (last_row) state_nx = ST_COMMIT;
      end
      ST_COMMIT: begin
        busy     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      row_idx <= '0;
      cur     <= SEED;
      nxt     <= '0;
      gen     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == ST_COMMIT);
      unique case (state)
        ST_IDLE: begin
          row_idx <= '0;
          if (bus.wr_en)
            cur[bus.wr_row][bus.wr_col] <= bus.wr_val;
        end
        ST_COMPUTE: begin
          nxt[row_idx] <= nrow;
          row_idx      <= row_idx + 1'b1;
        end
        ST_COMMIT: begin
          cur <= nxt;
          gen <= gen + 1'b1;
        end
        default: row_idx <= '0;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.rd_cell   = cur[bus.rd_row][bus.rd_col];
  assign bus.gen_count = gen;
endmodule
